// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard/flow
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

   // Controller FSM: normal issue, draining towards a halt, and halted.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } ctrl_state_t;

   // Register tag 0 is hard-wired zero and never creates a dependency.
   localparam int unsigned TAG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector. Flags an ID-stage
//               instruction that reads the destination of a load in EX.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
   import pipeline_ctrl_pkg::*;
#(
   parameter int TAG_WIDTH = 5
) (
   input  logic                 id_valid_i,
   input  logic [TAG_WIDTH-1:0] id_rs1_i,
   input  logic [TAG_WIDTH-1:0] id_rs2_i,
   input  logic                 id_uses_rs1_i,
   input  logic                 id_uses_rs2_i,
   input  logic                 ex_valid_i,
   input  logic [TAG_WIDTH-1:0] ex_tag_i,
   input  logic                 ex_is_load_i,
   output logic                 hazard_o
);

   logic w_rs1_match;
   logic w_rs2_match;
   logic w_ex_writes;

   // A source only matters if the instruction actually reads it.
   assign w_rs1_match = id_uses_rs1_i & (id_rs1_i == ex_tag_i);
   assign w_rs2_match = id_uses_rs2_i & (id_rs2_i == ex_tag_i);

   // Loads to the zero register produce nothing to wait for.
   assign w_ex_writes = ex_valid_i & ex_is_load_i &
                        (ex_tag_i != TAG_WIDTH'(TAG_ZERO));

   assign hazard_o = id_valid_i & w_ex_writes & (w_rs1_match | w_rs2_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central hazard and flow controller for the 5-stage pipeline.
//               Generates stall/flush/halt controls for the pipeline
//               registers, tracks deferred branch flushes across memory
//               stalls, sequences the halt drain and counts stall/flush events.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int tag_width = 5,
   parameter int cnt_width = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 id_valid,
   input  logic [tag_width-1:0] id_rs1,
   input  logic [tag_width-1:0] id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic                 id_is_halt,
   input  logic                 ex_valid,
   input  logic [tag_width-1:0] ex_tag,
   input  logic                 ex_is_load,
   input  logic                 branch_taken,
   input  logic                 mem_busy,
   input  logic                 wb_valid,
   input  logic                 wb_is_halt,
   output logic                 pc_stall,
   output logic                 if_id_stall,
   output logic                 if_id_flush,
   output logic                 id_ex_stall,
   output logic                 id_ex_flush,
   output logic                 ex_mem_stall,
   output logic                 mem_wb_stall,
   output logic                 halt,
   output logic [cnt_width-1:0] stall_count,
   output logic [cnt_width-1:0] flush_count
);

   ctrl_state_t          state_q, state_d;
   logic                 flush_pending_q, flush_pending_d;
   logic [cnt_width-1:0] stall_count_q, stall_count_d;
   logic [cnt_width-1:0] flush_count_q, flush_count_d;

   logic w_hazard;
   logic w_flush_cond;
   logic w_halted;
   logic w_flush_apply;
   logic w_lu_apply;

   load_use_detect #(
      .TAG_WIDTH (tag_width)
   ) u_load_use_detect (
      .id_valid_i    (id_valid),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_uses_rs1_i (id_uses_rs1),
      .id_uses_rs2_i (id_uses_rs2),
      .ex_valid_i    (ex_valid),
      .ex_tag_i      (ex_tag),
      .ex_is_load_i  (ex_is_load),
      .hazard_o      (w_hazard)
   );

   // A flush is wanted for a live taken branch or one deferred by mem_busy.
   assign w_flush_cond  = (ex_valid & branch_taken) | flush_pending_q;
   assign w_halted      = (state_q == HALTED);
   // Priority: HALTED > mem_busy > flush > load-use.
   assign w_flush_apply = ~w_halted & ~mem_busy & w_flush_cond;
   assign w_lu_apply    = ~w_halted & ~mem_busy & ~w_flush_cond & w_hazard;

   // Control outputs, next FSM state, pending flag and counter updates.
   always_comb begin
      pc_stall        = 1'b0;
      if_id_stall     = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_stall     = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem_stall    = 1'b0;
      mem_wb_stall    = 1'b0;
      halt            = 1'b0;
      state_d         = state_q;
      flush_pending_d = flush_pending_q;
      stall_count_d   = stall_count_q;
      flush_count_d   = flush_count_q;

      if (w_halted) begin
         halt     = 1'b1;
         pc_stall = 1'b1;
      end else if (mem_busy) begin
         // Flush is deliberately held off: a stall would mask it anyway.
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_stall = 1'b1;
      end else if (w_flush_cond) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (w_hazard) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end

      // While draining, keep the front end closed unless everything is stalled.
      if (state_q == DRAIN && !mem_busy) begin
         pc_stall    = 1'b1;
         if_id_flush = 1'b1;
      end

      case (state_q)
         RUN: begin
            if (id_valid && id_is_halt && !mem_busy && !w_flush_cond && !w_hazard)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (wb_valid && wb_is_halt)
               state_d = HALTED;
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase

      if (w_halted)
         flush_pending_d = 1'b0;
      else if (mem_busy)
         flush_pending_d = w_flush_cond;
      else
         flush_pending_d = 1'b0;

      if ((~w_halted & mem_busy) | w_lu_apply)
         stall_count_d = stall_count_q + cnt_width'(1);
      if (w_flush_apply)
         flush_count_d = flush_count_q + cnt_width'(1);
   end

   // State register; reset wins over enable, enable low freezes all state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= RUN;
         flush_pending_q <= 1'b0;
         stall_count_q   <= '0;
         flush_count_q   <= '0;
      end else if (enable) begin
         state_q         <= state_d;
         flush_pending_q <= flush_pending_d;
         stall_count_q   <= stall_count_d;
         flush_count_q   <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking testbench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        id_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic        id_is_halt;
   logic        ex_valid;
   logic [4:0]  ex_tag;
   logic        ex_is_load;
   logic        branch_taken;
   logic        mem_busy;
   logic        wb_valid;
   logic        wb_is_halt;
   logic        pc_stall;
   logic        if_id_stall;
   logic        if_id_flush;
   logic        id_ex_stall;
   logic        id_ex_flush;
   logic        ex_mem_stall;
   logic        mem_wb_stall;
   logic        halt;
   logic [31:0] stall_count;
   logic [31:0] flush_count;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_stall}
   logic [6:0] ctl;
   assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                 id_ex_flush, ex_mem_stall, mem_wb_stall};

   localparam logic [6:0] C_IDLE  = 7'b0000000;
   localparam logic [6:0] C_LU    = 7'b1100100;
   localparam logic [6:0] C_FLUSH = 7'b0010100;
   localparam logic [6:0] C_BUSY  = 7'b1101011;
   localparam logic [6:0] C_DRAIN = 7'b1010000;
   localparam logic [6:0] C_HALT  = 7'b1000000;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .tag_width (5),
      .cnt_width (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .id_is_halt   (id_is_halt),
      .ex_valid     (ex_valid),
      .ex_tag       (ex_tag),
      .ex_is_load   (ex_is_load),
      .branch_taken (branch_taken),
      .mem_busy     (mem_busy),
      .wb_valid     (wb_valid),
      .wb_is_halt   (wb_is_halt),
      .pc_stall     (pc_stall),
      .if_id_stall  (if_id_stall),
      .if_id_flush  (if_id_flush),
      .id_ex_stall  (id_ex_stall),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_stall (ex_mem_stall),
      .mem_wb_stall (mem_wb_stall),
      .halt         (halt),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   task automatic drive_idle();
      id_valid     = 1'b0;
      id_rs1       = 5'd0;
      id_rs2       = 5'd0;
      id_uses_rs1  = 1'b0;
      id_uses_rs2  = 1'b0;
      id_is_halt   = 1'b0;
      ex_valid     = 1'b0;
      ex_tag       = 5'd0;
      ex_is_load   = 1'b0;
      branch_taken = 1'b0;
      mem_busy     = 1'b0;
      wb_valid     = 1'b0;
      wb_is_halt   = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      reset  = 1'b1;
      enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_IDLE); end
      checks++;
      if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", halt); end
      checks++;
      if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
         errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", stall_count, flush_count);
      end
      reset = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
   endtask

   task automatic test_load_use();
      // rs1 matches a load destination
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
      ex_valid = 1'b1; ex_tag = 5'd5; ex_is_load = 1'b1;
      #1;
      checks++;
      if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1_ctl got %b exp %b", ctl, C_LU); end
      exp_stall++;
      // bubble now in EX
      @(negedge clk);
      ex_is_load = 1'b0; ex_valid = 1'b0;
      #1;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_bubble_ctl got %b exp %b", ctl, C_IDLE); end
      checks++;
      if (stall_count !== 32'(exp_stall)) begin errors++; $display("FAIL lu_count1 got %0d exp %0d", stall_count, exp_stall); end
      // load to x0 never stalls
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      ex_valid = 1'b1; ex_tag = 5'd0; ex_is_load = 1'b1;
      #1;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_tag0_ctl got %b exp %b", ctl, C_IDLE); end
      // rs2 match
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
      ex_valid = 1'b1; ex_tag = 5'd7; ex_is_load = 1'b1;
      #1;
      checks++;
      if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2_ctl got %b exp %b", ctl, C_LU); end
      exp_stall++;
      // same tags but rs2 not read
      @(negedge clk);
      id_uses_rs2 = 1'b0;
      #1;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_unused_ctl got %b exp %b", ctl, C_IDLE); end
      checks++;
      if (stall_count !== 32'(exp_stall)) begin errors++; $display("FAIL lu_count2 got %0d exp %0d", stall_count, exp_stall); end
   endtask

   task automatic test_branch();
      @(negedge clk);
      drive_idle();
      ex_valid = 1'b1; branch_taken = 1'b1;
      #1;
      checks++;
      if (ctl !== C_FLUSH) begin errors++; $display("FAIL br_ctl got %b exp %b", ctl, C_FLUSH); end
      exp_flush++;
      // branch together with a load-use match: flush wins, no stall counted
      @(negedge clk);
      checks++;
      if (flush_count !== 32'(exp_flush)) begin errors++; $display("FAIL br_count got %0d exp %0d", flush_count, exp_flush); end
      id_valid = 1'b1; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      ex_tag = 5'd9; ex_is_load = 1'b1;
      #1;
      checks++;
      if (ctl !== C_FLUSH) begin errors++; $display("FAIL br_lu_ctl got %b exp %b", ctl, C_FLUSH); end
      exp_flush++;
      @(negedge clk);
      drive_idle();
      checks++;
      if (stall_count !== 32'(exp_stall) || flush_count !== 32'(exp_flush)) begin
         errors++; $display("FAIL br_lu_counts got %0d/%0d exp %0d/%0d", stall_count, flush_count, exp_stall, exp_flush);
      end
   endtask

   task automatic test_mem_busy();
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         drive_idle();
         mem_busy = 1'b1;
         if (cyc == 1) begin ex_valid = 1'b1; branch_taken = 1'b1; end
         #1;
         checks++;
         if (ctl !== C_BUSY) begin errors++; $display("FAIL busy_ctl cyc %0d got %b exp %b", cyc, ctl, C_BUSY); end
         exp_stall++;
      end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (ctl !== C_FLUSH) begin errors++; $display("FAIL busy_deferred_flush got %b exp %b", ctl, C_FLUSH); end
      exp_flush++;
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL busy_after_ctl got %b exp %b", ctl, C_IDLE); end
      checks++;
      if (stall_count !== 32'(exp_stall) || flush_count !== 32'(exp_flush)) begin
         errors++; $display("FAIL busy_counts got %0d/%0d exp %0d/%0d", stall_count, flush_count, exp_stall, exp_flush);
      end
   endtask

   task automatic test_halt();
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_is_halt = 1'b1;
      #1;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL halt_id_ctl got %b exp %b", ctl, C_IDLE); end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (ctl !== C_DRAIN || halt !== 1'b0) begin errors++; $display("FAIL drain_ctl got %b/%b exp %b/0", ctl, halt, C_DRAIN); end
      @(negedge clk);
      mem_busy = 1'b1;
      #1;
      checks++;
      if (ctl !== C_BUSY) begin errors++; $display("FAIL drain_busy_ctl got %b exp %b", ctl, C_BUSY); end
      exp_stall++;
      @(negedge clk);
      drive_idle();
      wb_valid = 1'b1; wb_is_halt = 1'b1;
      #1;
      checks++;
      if (ctl !== C_DRAIN || halt !== 1'b0) begin errors++; $display("FAIL drain_wb_ctl got %b/%b exp %b/0", ctl, halt, C_DRAIN); end
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         drive_idle();
         ex_valid = 1'b1; branch_taken = 1'b1; mem_busy = (cyc == 1);
         #1;
         checks++;
         if (ctl !== C_HALT || halt !== 1'b1) begin errors++; $display("FAIL halted_ctl cyc %0d got %b/%b exp %b/1", cyc, ctl, halt, C_HALT); end
      end
      @(negedge clk);
      checks++;
      if (stall_count !== 32'(exp_stall) || flush_count !== 32'(exp_flush)) begin
         errors++; $display("FAIL halted_counts got %0d/%0d exp %0d/%0d", stall_count, flush_count, exp_stall, exp_flush);
      end
      drive_idle();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (ctl !== C_IDLE || halt !== 1'b0) begin errors++; $display("FAIL halt_reset_ctl got %b/%b exp %b/0", ctl, halt, C_IDLE); end
      checks++;
      if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
         errors++; $display("FAIL halt_reset_counts got %0d/%0d exp 0/0", stall_count, flush_count);
      end
      exp_stall = 0;
      exp_flush = 0;
   endtask

   task automatic test_halt_load_use();
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_is_halt = 1'b1; id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
      ex_valid = 1'b1; ex_tag = 5'd4; ex_is_load = 1'b1;
      #1;
      checks++;
      if (ctl !== C_LU) begin errors++; $display("FAIL halt_lu_ctl got %b exp %b", ctl, C_LU); end
      exp_stall++;
      @(negedge clk);
      ex_valid = 1'b0; ex_is_load = 1'b0;
      #1;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL halt_lu_still_run got %b exp %b", ctl, C_IDLE); end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (ctl !== C_DRAIN) begin errors++; $display("FAIL halt_lu_drain got %b exp %b", ctl, C_DRAIN); end
   endtask

   task automatic test_reset_in_drain();
      // already in DRAIN: defer a branch under mem_busy to set the pending flag
      @(negedge clk);
      drive_idle();
      mem_busy = 1'b1; ex_valid = 1'b1; branch_taken = 1'b1;
      #1;
      checks++;
      if (ctl !== C_BUSY) begin errors++; $display("FAIL drain_pend_ctl got %b exp %b", ctl, C_BUSY); end
      @(negedge clk);
      drive_idle();
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== C_IDLE || halt !== 1'b0) begin errors++; $display("FAIL rst_drain_ctl got %b/%b exp %b/0", ctl, halt, C_IDLE); end
      checks++;
      if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
         errors++; $display("FAIL rst_drain_counts got %0d/%0d exp 0/0", stall_count, flush_count);
      end
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL rst_drain_after got %b exp %b", ctl, C_IDLE); end
      exp_stall = 0;
      exp_flush = 0;
   endtask

   task automatic test_enable();
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_rs2 = 5'd12; id_uses_rs2 = 1'b1;
      ex_valid = 1'b1; ex_tag = 5'd12; ex_is_load = 1'b1;
      exp_stall++;
      @(negedge clk);
      drive_idle();
      enable = 1'b0;
      mem_busy = 1'b1; ex_valid = 1'b1; branch_taken = 1'b1;
      #1;
      checks++;
      if (ctl !== C_BUSY) begin errors++; $display("FAIL en_off_ctl got %b exp %b", ctl, C_BUSY); end
      @(negedge clk);
      drive_idle();
      id_valid = 1'b1; id_is_halt = 1'b1;
      @(negedge clk);
      drive_idle();
      enable = 1'b1;
      #1;
      checks++;
      if (ctl !== C_IDLE) begin errors++; $display("FAIL en_frozen_ctl got %b exp %b", ctl, C_IDLE); end
      checks++;
      if (stall_count !== 32'(exp_stall) || flush_count !== 32'(exp_flush)) begin
         errors++; $display("FAIL en_counts got %0d/%0d exp %0d/%0d", stall_count, flush_count, exp_stall, exp_flush);
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      drive_idle();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_busy();
      test_halt();
      test_halt_load_use();
      test_reset_in_drain();
      test_enable();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and flow controller for the 5-stage pipeline. It watches the valid/tag outputs of the IF/ID, ID/EX, EX/MEM and MEM/WB `pipeline_reg` instances and generates their `stall`, `branch` (flush) and `halt` controls, plus the PC hold. It resolves load-use hazards, multi-cycle memory stalls, taken-branch squashes and the halt-drain sequence, and keeps stall/flush event counters.

## Interface
- `tag_width`, 5: register-tag width.
- `cnt_width`, 32: event-counter width.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  global enable; low freezes FSM, pending flag and counters.
- `id_valid`  in  1  IF/ID valid_out.
- `id_rs1`, `id_rs2`  in  tag_width  source tags of the ID instruction.
- `id_uses_rs1`, `id_uses_rs2`  in  1  source actually read.
- `id_is_halt`  in  1  ID instruction is ecall/ebreak.
- `ex_valid`  in  1  ID/EX valid_out.
- `ex_tag`  in  tag_width  EX destination tag.
- `ex_is_load`  in  1  EX instruction is a load.
- `branch_taken`  in  1  EX resolved a taken branch/jump.
- `mem_busy`  in  1  data memory not ready this cycle.
- `wb_valid`  in  1  MEM/WB valid_out.
- `wb_is_halt`  in  1  WB instruction is the halt.
- `pc_stall`  out  1  hold PC.
- `if_id_stall`, `if_id_flush`  out  1  IF/ID controls.
- `id_ex_stall`, `id_ex_flush`  out  1  ID/EX controls.
- `ex_mem_stall`, `mem_wb_stall`  out  1  EX/MEM and MEM/WB stall.
- `halt`  out  1  to every pipeline_reg `halt`.
- `stall_count`, `flush_count`  out  cnt_width  event counters.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset → RUN.
- Priority for outputs: HALTED > mem_busy > flush > load-use.
- mem_busy: all five stall outputs = 1, both flush outputs = 0 (a stall overrides a flush inside `pipeline_reg`, so flush must not be relied on here).
- Flush condition: `ex_valid & branch_taken`, or `flush_pending`. Outputs: `if_id_flush = id_ex_flush = 1`, `pc_stall = 0` so the PC loads the target.
- `flush_pending` is set when the flush condition is seen while mem_busy. It is cleared on the first non-busy cycle, in which the flush is applied.
- Load-use condition: `id_valid & ex_valid & ex_is_load & ex_tag != 0 & ((id_uses_rs1 & id_rs1 == ex_tag) | (id_uses_rs2 & id_rs2 == ex_tag))`. Outputs: `pc_stall = if_id_stall = 1`, `id_ex_flush = 1` (inserts a bubble). Suppressed when a flush is applied.
- RUN → DRAIN when `id_valid & id_is_halt`, with no mem_busy, no flush and no load-use stall that cycle (the halt advances into ID/EX).
- DRAIN: `pc_stall = 1` and `if_id_flush = 1`, so no new instructions enter. mem_busy still stalls everything.
- DRAIN → HALTED when `wb_valid & wb_is_halt`.
- HALTED: `halt = 1` and `pc_stall = 1`. Only reset exits.
- Outputs not named above are 0.
- `stall_count` increments by 1 each enabled cycle with a load-use or mem_busy stall.
- `flush_count` increments by 1 each enabled cycle in which a branch flush is applied.
- Both counters wrap modulo 2^cnt_width.

## Timing
- All control outputs are combinational from the inputs and registered state, and are consumed at the same clock edge. Zero-cycle latency.
- Registered state: FSM, `flush_pending`, counters. They update on posedge `clk` when `enable = 1`.
- Reset, including mid-operation: FSM → RUN, `flush_pending` = 0, counters = 0. During and after reset, `halt = 0` and all stall/flush outputs evaluate from the inputs with state = RUN.
- A load-use hazard lasts exactly 1 cycle: the bubble clears `ex_is_load`.
- Simultaneous load-use and branch in the same cycle: only the flush is applied, and `stall_count` does not increment.
- Branch during mem_busy: the flush is applied on the cycle busy drops. `flush_count` increments once.

## Structure
- Package `pipeline_ctrl_pkg` holds `ctrl_state_t` (RUN, DRAIN, HALTED) and the reserved zero-tag constant `TAG_ZERO`.
- Sub-module `load_use_detect` is combinational: tag compare → `hazard`.

## Test plan
- ex load with `ex_tag` = 5, id `rs1` = 5 used → 1 cycle of `pc_stall`/`if_id_stall`/`id_ex_flush`, `stall_count` = 1. Repeat with `ex_tag` = 0 → no stall.
- `branch_taken` with `ex_valid` → `if_id_flush = id_ex_flush = 1`, `pc_stall = 0`, `flush_count` = 1. Same cycle with a load-use match → `stall_count` unchanged.
- mem_busy for 3 cycles with a branch in cycle 1 → all stalls high for 3 cycles, no flush. The flush appears in cycle 4; `stall_count` = 3, `flush_count` = 1.
- Halt in ID → DRAIN next cycle with `if_id_flush` held. After the halt reaches WB → `halt = 1` permanently. Reset → RUN, `halt = 0`.
- Halt in ID in the same cycle as a load-use stall → stays RUN and enters DRAIN one cycle later.
- Reset asserted in DRAIN with `flush_pending` set → RUN, pending cleared, counters 0. With `enable` low, nothing changes state.
